lossy_valid_to_stream_q: RTL and testbench

Converts a valid-only producer (no back-pressure) into a ready/valid stream through a configurable-depth buffer that discards data instead of stalling when full. Successor to the fixed two-entry lossy converter. Adds parametrised depth, a selectable discard policy, an occupancy output, a drop indication with a saturating drop counter, and a synchronous flush. It sits at boundaries where the source cannot be stalled, such as status/event sources feeding a handshaked interconnect.

---
 rtl/lossy_valid_to_stream_q.sv | 199 +++++++++++++++++++
 tb/tb_lossy_valid_to_stream_q.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lossy_valid_to_stream_q.sv
// lossy_valid_to_stream_q
//
// Turns a valid-only producer (which cannot be stalled) into a ready/valid
// stream. Samples are held in an output register followed by a circular
// pending FIFO of Depth-1 slots. When everything is full and the consumer
// does not take a beat, the incoming sample is kept at the cost of another
// entry, so data is discarded and the producer is never stalled.
//
// Parameters
//   DataWidth  - payload width
//   Depth      - total entries (output register + Depth-1 pending), >= 2
//   DropOldest - 0: overwrite newest pending entry when full
//                1: discard oldest pending entry when full
//   CntWidth   - width of the saturating drop counter
//
// Ports
//   clk         clock
//   rst_n       asynchronous reset, active high
//   flush_i     synchronous clear of all buffered data
//   valid_i     input sample valid (no ready)
//   data_i      input payload
//   valid_o     output stream valid
//   data_o      output stream payload
//   ready_i     output stream ready
//   busy_o      at least one entry is held
//   usage_o     registered occupancy (output register + pending)
//   drop_o      a sample is discarded this cycle (combinational)
//   drop_cnt_o  saturating count of discarded samples
module lossy_valid_to_stream_q #(
    parameter int DataWidth  = 32,
    parameter int Depth      = 4,
    parameter bit DropOldest = 1'b0,
    parameter int CntWidth   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [DataWidth-1:0]         data_i,
    output logic                         valid_o,
    output logic [DataWidth-1:0]         data_o,
    input  logic                         ready_i,
    output logic                         busy_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o,
    output logic                         drop_o,
    output logic [CntWidth-1:0]          drop_cnt_o
);

    localparam int Slots    = Depth - 1;
    localparam int PtrWidth = (Slots > 1) ? $clog2(Slots) : 1;
    localparam int UseWidth = $clog2(Depth + 1);

    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Slots - 1);
    localparam logic [UseWidth-1:0] SlotsU  = UseWidth'(Slots);

    if (Depth < 2) begin : g_depth_check
        $error("lossy_valid_to_stream_q: Depth must be at least 2");
    end

    // Pointer arithmetic wraps modulo the number of pending slots, which
    // need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PtrWidth-1:0] ptr_dec(input logic [PtrWidth-1:0] p);
        return (p == '0) ? LastPtr : p - 1'b1;
    endfunction

    // Pending storage
    logic [DataWidth-1:0] mem [Slots];
    logic                 mem_we;
    logic [PtrWidth-1:0]  mem_addr;
    logic [DataWidth-1:0] head_data;

    // State
    logic                 out_valid_reg, out_valid_next;
    logic [DataWidth-1:0] out_data_reg,  out_data_next;
    logic [PtrWidth-1:0]  rd_ptr_reg,    rd_ptr_next;
    logic [PtrWidth-1:0]  wr_ptr_reg,    wr_ptr_next;
    logic [UseWidth-1:0]  cnt_reg,       cnt_next;
    logic [UseWidth-1:0]  usage_reg,     usage_next;
    logic [CntWidth-1:0]  drop_cnt_reg;

    // Per-cycle decisions
    logic pop;
    logic fifo_empty;
    logic fifo_full;
    logic take_head;
    logic load_direct;
    logic push;
    logic drop;

    assign head_data  = mem[rd_ptr_reg];
    assign pop        = out_valid_reg & ready_i;
    assign fifo_empty = (cnt_reg == '0);
    assign fifo_full  = (cnt_reg == SlotsU);
    assign take_head  = pop & ~fifo_empty;

    // A sample bypasses the FIFO only when nothing is queued ahead of it and
    // the output register is free (or being freed by this cycle's pop).
    assign load_direct = valid_i & (~out_valid_reg | pop) & fifo_empty;

    // A pop frees a pending slot in the same cycle, so a full FIFO with a
    // pop still accepts without discarding anything.
    assign push = valid_i & ~load_direct & (~fifo_full | pop);
    assign drop = valid_i & ~flush_i & fifo_full & ~pop;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        cnt_next       = cnt_reg;
        mem_we         = 1'b0;
        mem_addr       = wr_ptr_reg;

        if (flush_i) begin
            // Everything is discarded; a coincident sample becomes the
            // only entry.
            out_valid_next = valid_i;
            if (valid_i) begin
                out_data_next = data_i;
            end
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            cnt_next    = '0;
        end else begin
            if (take_head) begin
                out_data_next = head_data;
                rd_ptr_next   = ptr_inc(rd_ptr_reg);
            end else if (pop) begin
                out_valid_next = 1'b0;
            end

            if (load_direct) begin
                out_valid_next = 1'b1;
                out_data_next  = data_i;
            end

            if (push) begin
                mem_we      = 1'b1;
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end

            if (drop) begin
                mem_we = 1'b1;
                if (DropOldest) begin
                    // Full FIFO: wr == rd, so writing the tail replaces the
                    // oldest entry; both pointers step past it.
                    rd_ptr_next = ptr_inc(rd_ptr_reg);
                    wr_ptr_next = ptr_inc(wr_ptr_reg);
                end else begin
                    mem_addr = ptr_dec(wr_ptr_reg);
                end
            end

            cnt_next = cnt_reg + UseWidth'(push) - UseWidth'(take_head);
        end

        usage_next = cnt_next + UseWidth'(out_valid_next);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            usage_reg     <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            cnt_reg       <= cnt_next;
            usage_reg     <= usage_next;
            if (drop && (drop_cnt_reg != {CntWidth{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign valid_o    = out_valid_reg;
    assign data_o     = out_data_reg;
    assign usage_o    = usage_reg;
    assign busy_o     = (usage_reg != '0);
    assign drop_o     = drop & ~rst_n;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_lossy_valid_to_stream_q.sv
// Testbench for lossy_valid_to_stream_q.
// Four instances share one stimulus stream:
//   inst0: Depth 4, overwrite newest, 16-bit counter
//   inst1: Depth 4, discard oldest,   16-bit counter
//   inst2: Depth 4, overwrite newest, 2-bit counter (saturation)
//   inst3: Depth 3, discard oldest,   16-bit counter (non power-of-two wrap)
// The reference model keeps each instance's contents as a plain queue.
module tb_lossy_valid_to_stream_q;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       ready_i = 1'b0;

    logic        valid_w [NI];
    logic [7:0]  data_w  [NI];
    logic [2:0]  usage_w [NI];
    logic        busy_w  [NI];
    logic        drop_w  [NI];
    logic [15:0] dcnt_w  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int D  = (gi == 3) ? 3 : 4;
        localparam bit DO = (gi == 1) || (gi == 3);
        localparam int CW = (gi == 2) ? 2 : 16;

        logic                     v;
        logic                     b;
        logic                     dr;
        logic [7:0]               d;
        logic [$clog2(D+1)-1:0]   u;
        logic [CW-1:0]            c;

        lossy_valid_to_stream_q #(
            .DataWidth (8),
            .Depth     (D),
            .DropOldest(DO),
            .CntWidth  (CW)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush_i),
            .valid_i   (valid_i),
            .data_i    (data_i),
            .valid_o   (v),
            .data_o    (d),
            .ready_i   (ready_i),
            .busy_o    (b),
            .usage_o   (u),
            .drop_o    (dr),
            .drop_cnt_o(c)
        );

        assign valid_w[gi] = v;
        assign data_w[gi]  = d;
        assign usage_w[gi] = 3'(u);
        assign busy_w[gi]  = b;
        assign drop_w[gi]  = dr;
        assign dcnt_w[gi]  = 16'(c);
    end

    function automatic int dep_of(input int k);
        return (k == 3) ? 3 : 4;
    endfunction

    function automatic bit old_of(input int k);
        return (k == 1) || (k == 3);
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    // Reference model and scoreboard
    logic [7:0] mdl  [NI][$];   // held entries, front = output register
    logic [7:0] expq [NI][$];   // beats expected on the output handshake
    logic [7:0] seen [NI][$];   // beats observed, for directed order checks
    int         dcnt_m [NI];

    logic       exp_valid [NI];
    logic [7:0] exp_head  [NI];
    int         exp_usage [NI];
    int         exp_dcnt  [NI];
    logic       exp_drop  [NI];

    bit mon_en  = 1'b0;
    bit verbose = 1'b1;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h expected %0h", name, k, act, exp);
    endtask

    // One clock cycle of stimulus; the model is advanced for the coming edge.
    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit rdy, input bit f);
        @(negedge clk);
        rst_n   = r;
        valid_i = v;
        data_i  = d;
        ready_i = rdy;
        flush_i = f;
        for (int k = 0; k < NI; k++) begin
            exp_drop[k] = 1'b0;
            if (r) begin
                mdl[k].delete();
                dcnt_m[k] = 0;
            end
            exp_valid[k] = (mdl[k].size() != 0);
            exp_head[k]  = exp_valid[k] ? mdl[k][0] : 8'h00;
            exp_usage[k] = mdl[k].size();
            exp_dcnt[k]  = dcnt_m[k];
            if (!r) begin
                if (rdy && mdl[k].size() != 0) expq[k].push_back(mdl[k].pop_front());
                if (f) begin
                    mdl[k].delete();
                    if (v) mdl[k].push_back(d);
                end else if (v) begin
                    if (mdl[k].size() < dep_of(k)) begin
                        mdl[k].push_back(d);
                    end else begin
                        exp_drop[k] = 1'b1;
                        if (dcnt_m[k] < cmax_of(k)) dcnt_m[k]++;
                        if (old_of(k)) begin
                            mdl[k].delete(1);
                            mdl[k].push_back(d);
                        end else begin
                            mdl[k][mdl[k].size() - 1] = d;
                        end
                    end
                end
            end
        end
        mon_en = 1'b1;
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                for (int k = 0; k < NI; k++) begin
                    chk("valid", k, 32'(valid_w[k]), 32'(exp_valid[k]));
                    if (exp_valid[k]) chk("data_hold", k, 32'(data_w[k]), 32'(exp_head[k]));
                    chk("usage", k, 32'(usage_w[k]), exp_usage[k]);
                    chk("busy", k, 32'(busy_w[k]), 32'(exp_usage[k] != 0));
                    chk("drop", k, 32'(drop_w[k]), 32'(exp_drop[k]));
                    chk("drop_cnt", k, 32'(dcnt_w[k]), exp_dcnt[k]);
                    if (valid_w[k] && ready_i) begin
                        int n;
                        n = expq[k].size();
                        chk("beat_pending", k, 32'(n > 0), 32'd1);
                        if (n > 0) chk("beat_data", k, 32'(data_w[k]), 32'(expq[k].pop_front()));
                        seen[k].push_back(data_w[k]);
                        if (verbose) $display("beat inst%0d data %0h", k, data_w[k]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] want0 [4];
        logic [7:0] want1 [4];
        want0 = '{8'd10, 8'd11, 8'd12, 8'd15};
        want1 = '{8'd10, 8'd13, 8'd14, 8'd15};

        // Reset
        repeat (3) cyc(1, 0, 8'h00, 0, 0);

        // Streaming at full rate
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'(i), 1, 0);
        repeat (2) cyc(0, 0, 8'h00, 1, 0);

        // Overflow with the consumer stalled
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'(10 + i), 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        #2;
        chk("burst_usage", 0, 32'(usage_w[0]), 32'd4);
        chk("burst_usage", 1, 32'(usage_w[1]), 32'd4);
        chk("burst_drops", 0, 32'(dcnt_w[0]), 32'd2);
        chk("burst_drops", 1, 32'(dcnt_w[1]), 32'd2);
        for (int k = 0; k < NI; k++) seen[k].delete();
        repeat (5) cyc(0, 0, 8'h00, 1, 0);
        #2;
        chk("order_len", 0, 32'(seen[0].size()), 32'd4);
        chk("order_len", 1, 32'(seen[1].size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen[0].size()) chk("order_newest", 0, 32'(seen[0][i]), 32'(want0[i]));
            if (i < seen[1].size()) chk("order_oldest", 1, 32'(seen[1][i]), 32'(want1[i]));
        end

        // Full buffer with a simultaneous pop, then saturating drops
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(20 + i), 0, 0);
        cyc(0, 1, 8'd24, 1, 0);
        #2;
        chk("full_pop_no_drop", 0, 32'(drop_w[0]), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'(25 + i), 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        #2;
        chk("total_drops", 0, 32'(dcnt_w[0]), 32'd5);
        chk("total_drops", 1, 32'(dcnt_w[1]), 32'd5);
        chk("saturated", 2, 32'(dcnt_w[2]), 32'd3);

        // Flush with a coincident sample
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 1, 8'h55, 0, 1);
        cyc(0, 0, 8'h00, 0, 0);
        #2;
        chk("flush_valid", 0, 32'(valid_w[0]), 32'd1);
        chk("flush_data", 0, 32'(data_w[0]), 32'h55);
        chk("flush_usage", 0, 32'(usage_w[0]), 32'd1);
        chk("flush_keeps_cnt", 0, 32'(dcnt_w[0]), 32'd5);

        // Asynchronous reset mid-stream
        cyc(0, 1, 8'h33, 0, 0);
        cyc(0, 1, 8'h34, 0, 0);
        #3;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("async_valid", k, 32'(valid_w[k]), 32'd0);
            chk("async_data", k, 32'(data_w[k]), 32'd0);
            chk("async_usage", k, 32'(usage_w[k]), 32'd0);
            chk("async_busy", k, 32'(busy_w[k]), 32'd0);
            chk("async_drop", k, 32'(drop_w[k]), 32'd0);
            chk("async_cnt", k, 32'(dcnt_w[k]), 32'd0);
            mdl[k].delete();
            dcnt_m[k] = 0;
        end
        repeat (2) cyc(1, 1, 8'h00, 1, 0);

        // Random soak
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            cyc(0, $urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 45,
                $urandom_range(0, 199) == 0);
        end

        // Drain and confirm nothing is left outstanding
        repeat (8) cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);
        #2;
        for (int k = 0; k < NI; k++) begin
            chk("drained_beats", k, 32'(expq[k].size()), 32'd0);
            chk("drained_valid", k, 32'(valid_w[k]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
